uart_tx_arbiter: RTL and testbench

Shares one uart_tx byte transmitter between N_REQ independent byte-stream requesters.
- Arbitration is round-robin. A grant is locked for a whole message, which ends at i_req_last or when the MAX_BURST cap is reached.
- When HEADER_EN=1, each granted message is preceded by a channel header byte.
- Sits between firmware/debug byte sources and uart_tx. It drives uart_tx's i_data / i_data_valid and observes its o_data_rdy.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx byte-stream arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [7:0] HDR_TAG = 8'h80;

  // A cap of 0 means unlimited, which still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

  function automatic logic [7:0] hdr_byte(input int ch);
    return HDR_TAG | {5'b00000, ch[2:0]};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx facing signals of the arbiter, bundled for port lists.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ*8-1:0] i_req_data;
  logic [N_REQ-1:0]   i_req_valid;
  logic [N_REQ-1:0]   i_req_last;
  logic [N_REQ-1:0]   o_req_ready;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_rdy;
  logic [N_REQ-1:0]   o_grant;
  logic               o_busy;

  modport slave (
    input  i_req_data, i_req_valid, i_req_last, i_tx_rdy,
    output o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy
  );

  modport master (
    output i_req_data, i_req_valid, i_req_last, i_tx_rdy,
    input  o_req_ready, o_tx_data, o_tx_valid, o_grant, o_busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          found
);

  always_comb begin
    logic [IW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte-stream requesters, round-robin per message,
// with an optional channel header byte ahead of each grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int HEADER_EN = 1,
  parameter int MAX_BURST = 16
) (
  input logic              i_clk,
  input logic              i_rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(MAX_BURST);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   pick_grant;
  logic               pick_found;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_idx, pick_idx;
  logic [CW-1:0]      count_q, count_d;
  logic               last_q, last_d;
  logic               hdr_q, hdr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               burst_done;

  function automatic logic [IW-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (oh[k]) idx = IW'(k);
    end
    return idx;
  endfunction

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (bus.i_req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .found (pick_found)
  );

  assign pick_idx   = onehot_to_idx(pick_grant);
  assign grant_idx  = onehot_to_idx(grant_q);
  assign burst_done = (MAX_BURST != 0) && (count_q == CW'(MAX_BURST));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= IW'(N_REQ - 1);
      count_q   <= '0;
      last_q    <= 1'b0;
      hdr_q     <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      hdr_q     <= hdr_d;
      tx_data_q <= tx_data_d;
    end
  end

  // S_GAP guarantees a dead cycle after every TX transfer, covering uart_tx's late rdy fall.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    count_d   = count_q;
    last_d    = last_q;
    hdr_d     = hdr_q;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_grant;
          count_d = '0;
          if (HEADER_EN != 0) begin
            tx_data_d = hdr_byte(int'(pick_idx));
            state_d   = S_HDR;
          end else begin
            state_d   = S_FETCH;
          end
        end
      end
      S_HDR: begin
        if (bus.i_tx_rdy) begin
          hdr_d   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_FETCH: begin
        if (|(bus.i_req_valid & grant_q)) begin
          tx_data_d = bus.i_req_data[{grant_idx, 3'b000} +: 8];
          last_d    = bus.i_req_last[grant_idx];
          count_d   = count_q + 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.i_tx_rdy) state_d = S_GAP;
      end
      S_GAP: begin
        if (hdr_q) begin
          hdr_d   = 1'b0;
          state_d = S_FETCH;
        end else if (last_q || burst_done) begin
          rr_ptr_d = grant_idx;
          grant_d  = '0;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_valid  = (state_q == S_HDR) || (state_q == S_SEND);
  assign bus.o_req_ready = (state_q == S_FETCH) ? grant_q : '0;
  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a message-level round-robin model predicts the
// TX byte stream, a monitor compares every uart_tx handshake against it.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  typedef struct packed {
    logic [7:0]   data;
    logic [N-1:0] grant;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ     (N),
    .HEADER_EN (1),
    .MAX_BURST (MB)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // chq feeds the requester drivers, mq is the model's own copy, exp_q the predicted TX stream
  logic [8:0] chq [N][$];
  logic [8:0] mq  [N][$];
  exp_t       exp_q[$];
  int         rr_model;
  int         n_vec = 0;
  int         n_err = 0;
  bit         force_rdy = 1'b0;
  bit         late = 1'b0;
  bit         prev_xfer = 1'b0;
  int         busy_cnt = 0;
  int         cyc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input int ch, input int len, input logic [7:0] first,
                               input logic [7:0] step, input bit rnd);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      logic [8:0] it;
      d  = rnd ? 8'($urandom) : 8'(first + step * i);
      it = {(i == len - 1), d};
      chq[ch].push_back(it);
      mq[ch].push_back(it);
    end
  endtask

  // Message-level arbitration: next non-empty channel after the last one served,
  // header first, then bytes until the message ends or the burst cap is hit.
  task automatic modelRound();
    forever begin
      int           k;
      int           n;
      bit           found;
      logic [8:0]   it;
      logic [N-1:0] oh;
      found = 1'b0;
      k     = 0;
      for (int i = 1; i <= N; i++) begin
        if (!found && mq[(rr_model + i) % N].size() > 0) begin
          k     = (rr_model + i) % N;
          found = 1'b1;
        end
      end
      if (!found) break;
      oh    = '0;
      oh[k] = 1'b1;
      exp_q.push_back({8'h80 + 8'(k), oh});
      n = 0;
      do begin
        it = mq[k].pop_front();
        exp_q.push_back({it[7:0], oh});
        n++;
      end while (!it[8] && n < MB);
      rr_model = k;
    end
  endtask

  task automatic waitDrain(input string name);
    bit done;
    int c;
    done = 1'b0;
    c    = 0;
    while (!done && c < 4000) begin
      @(negedge clk);
      c++;
      done = (exp_q.size() == 0) && !bus.o_busy;
      for (int k = 0; k < N; k++) if (chq[k].size() != 0) done = 1'b0;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s_timeout: %0d bytes still expected after %0d cycles", name, exp_q.size(), c);
    end
    @(negedge clk);
    checkOutput({name, "_grant_idle"}, 32'(bus.o_grant), 32'(0));
    checkOutput({name, "_busy_idle"}, 32'(bus.o_busy), 32'(0));
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_tx_valid"}, 32'(bus.o_tx_valid), 32'(0));
    checkOutput({name, "_tx_data"}, 32'(bus.o_tx_data), 32'(0));
    checkOutput({name, "_req_ready"}, 32'(bus.o_req_ready), 32'(0));
    checkOutput({name, "_grant"}, 32'(bus.o_grant), 32'(0));
    checkOutput({name, "_busy"}, 32'(bus.o_busy), 32'(0));
  endtask

  // Monitor, requester drivers and a uart_tx-like sink (rdy falls one cycle late).
  initial begin : env
    exp_t         e;
    logic [N-1:0] take;
    forever begin
      @(negedge clk);
      take = '0;
      if (rst_n) begin
        if (prev_xfer) checkOutput("tx_valid_gap", 32'(bus.o_tx_valid), 32'(0));
        prev_xfer = bus.o_tx_valid && bus.i_tx_rdy;
        if (prev_xfer) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL unexpected_tx: got 0x%0h, expected no transfer", bus.o_tx_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("tx_data", 32'(bus.o_tx_data), 32'(e.data));
            checkOutput("tx_grant", 32'(bus.o_grant), 32'(e.grant));
          end
        end
        for (int k = 0; k < N; k++) take[k] = bus.i_req_valid[k] && bus.o_req_ready[k];
      end else begin
        prev_xfer = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        logic [8:0] it;
        if (take[k]) void'(chq[k].pop_front());
        if (chq[k].size() > 0) begin
          it = chq[k][0];
          bus.i_req_valid[k]       = 1'b1;
          bus.i_req_data[8*k +: 8] = it[7:0];
          bus.i_req_last[k]        = it[8];
        end else begin
          bus.i_req_valid[k]       = 1'b0;
          bus.i_req_data[8*k +: 8] = 8'h00;
          bus.i_req_last[k]        = 1'b0;
        end
      end
      if (!rst_n) begin
        bus.i_tx_rdy = 1'b1;
        late         = 1'b0;
        busy_cnt     = 0;
      end else if (prev_xfer) begin
        late = 1'b1;
      end else if (late) begin
        late = 1'b0;
        if (!force_rdy) begin
          busy_cnt     = int'($urandom_range(1, 6));
          bus.i_tx_rdy = 1'b0;
        end
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.i_tx_rdy = 1'b1;
      end
    end
  end

  initial begin : main
    rst_n           = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    bus.i_tx_rdy    = 1'b1;
    rr_model        = N - 1;

    // Reset with every requester asserting valid
    for (int k = 0; k < N; k++) applyStimulus(k, 1, 8'hC0 + 8'(k), 8'h00, 1'b0);
    modelRound();
    repeat (3) @(posedge clk);
    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    waitDrain("t1");

    // Single channel, two-byte message
    @(posedge clk);
    #2;
    applyStimulus(2, 2, 8'h11, 8'h11, 1'b0);
    modelRound();
    waitDrain("t2");

    // All channels, back-to-back single-byte messages
    @(posedge clk);
    #2;
    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < N; k++) applyStimulus(k, 1, 8'hC0 + 8'(k), 8'h00, 1'b0);
    modelRound();
    waitDrain("t3");

    // Burst cap splits a long message around a competing requester
    @(posedge clk);
    #2;
    applyStimulus(1, 6, 8'hA1, 8'h01, 1'b0);
    applyStimulus(2, 1, 8'hB1, 8'h00, 1'b0);
    modelRound();
    waitDrain("t4");

    // Random rounds; every third one with the sink's rdy stuck high
    for (int r = 0; r < 9; r++) begin
      @(posedge clk);
      #2;
      force_rdy = (r % 3 == 2);
      if (force_rdy) begin
        bus.i_tx_rdy = 1'b1;
        busy_cnt     = 0;
      end
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          int nm;
          nm = int'($urandom_range(1, 2));
          for (int m = 0; m < nm; m++) applyStimulus(k, int'($urandom_range(1, 7)), 8'h00, 8'h00, 1'b1);
        end
      end
      modelRound();
      waitDrain(force_rdy ? "t5_stuck_rdy" : "rnd");
    end
    force_rdy = 1'b0;

    // Asynchronous reset while a data byte is being offered
    @(posedge clk);
    #2;
    applyStimulus(1, 6, 8'h00, 8'h00, 1'b1);
    applyStimulus(2, 3, 8'h00, 8'h00, 1'b1);
    modelRound();
    cyc = 0;
    while (bus.o_req_ready == '0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    while (!bus.o_tx_valid && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 1000) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL t6_reach_send: no data byte offered within %0d cycles", cyc);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("t6_async_reset");
    for (int k = 0; k < N; k++) begin
      chq[k].delete();
      mq[k].delete();
    end
    exp_q.delete();
    rr_model = N - 1;
    applyStimulus(3, 2, 8'h00, 8'h00, 1'b1);
    applyStimulus(0, 2, 8'h00, 8'h00, 1'b1);
    modelRound();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitDrain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
